// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port between ALU and load writeback, with forwarding lookups.
// Optional REGARB_XZR_EN: writes to ZERO_REG are accepted but dropped, and lookups of ZERO_REG never hit.
module regfile_write_arbiter #(
    parameter int n = 63,
    parameter logic [4:0] ZERO_REG = 5'd31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [4:0]   alu_reg,
    input  logic [n:0]   alu_data,
    input  logic         mem_valid,
    output logic         mem_ready,
    input  logic [4:0]   mem_reg,
    input  logic [n:0]   mem_data,
    output logic         RegWrite,
    output logic [4:0]   Write_register,
    output logic [n:0]   Write_data,
    input  logic [4:0]   lkp_reg1,
    input  logic [4:0]   lkp_reg2,
    output logic         fwd_hit1,
    output logic         fwd_hit2,
    output logic [n:0]   fwd_data
);
`ifdef REGARB_XZR_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif
    logic       ptr;
    logic       grant;
    logic       wr_en;
    logic [4:0] sel_reg;
    logic [n:0] sel_data;
    always_comb begin
        alu_ready = !reset && alu_valid && (!mem_valid || !ptr);
        mem_ready = !reset && mem_valid && (!alu_valid || ptr);
        grant     = alu_ready || mem_ready;
        sel_reg   = mem_ready ? mem_reg : alu_reg;
        sel_data  = mem_ready ? mem_data : alu_data;
        wr_en     = grant && !(XZR && sel_reg == ZERO_REG);
        fwd_hit1  = RegWrite && lkp_reg1 == Write_register && !(XZR && lkp_reg1 == ZERO_REG);
        fwd_hit2  = RegWrite && lkp_reg2 == Write_register && !(XZR && lkp_reg2 == ZERO_REG);
        fwd_data  = Write_data;
    end
    // Address and data hold across idle cycles; only RegWrite drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite       <= 1'b0;
            Write_register <= '0;
            Write_data     <= '0;
            ptr            <= 1'b0;
        end else begin
            RegWrite <= wr_en;
            if (grant) begin
                Write_register <= sel_reg;
                Write_data     <= sel_data;
            end
            if (alu_valid && mem_valid) ptr <= !ptr;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus randomized traffic checked against a rule-level model.
module tb_regfile_write_arbiter;
    localparam int N = 63;
`ifdef REGARB_XZR_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    logic alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0] alu_reg, mem_reg, Write_register, lkp_reg1, lkp_reg2;
    logic [N:0] alu_data, mem_data, Write_data, fwd_data;
    logic RegWrite, fwd_hit1, fwd_hit2;
    int compared = 0;
    int mismatched = 0;

    regfile_write_arbiter #(.n(N), .ZERO_REG(5'd31)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
        .lkp_reg1(lkp_reg1), .lkp_reg2(lkp_reg2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1; alu_valid = 0; mem_valid = 0;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; alu_valid = 1; mem_valid = 1; alu_reg = 3; mem_reg = 4;
        lkp_reg1 = 0; lkp_reg2 = 0; alu_data = '1; mem_data = '1;
        @(negedge clk);
        compared++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            mismatched++; $display("FAIL reset_ready: got %b%b want 00", alu_ready, mem_ready);
        end
        compared++;
        if (RegWrite !== 1'b0 || Write_register !== 5'd0 || Write_data !== '0) begin
            mismatched++; $display("FAIL reset_out: got we=%b reg=%0d data=%h want 0/0/0", RegWrite, Write_register, Write_data);
        end
        reset = 0; alu_valid = 0; mem_valid = 0;
    endtask

    task automatic test_single();
        do_reset();
        alu_valid = 1; alu_reg = 5; alu_data = 64'h1234;
        #1;
        compared++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            mismatched++; $display("FAIL single_ready: got %b%b want 10", alu_ready, mem_ready);
        end
        @(negedge clk);
        alu_valid = 0;
        compared++;
        if (RegWrite !== 1'b1 || Write_register !== 5'd5 || Write_data !== 64'h1234) begin
            mismatched++; $display("FAIL single_out: got we=%b reg=%0d data=%h want 1/5/1234", RegWrite, Write_register, Write_data);
        end
        @(negedge clk);
        compared++;
        if (RegWrite !== 1'b0 || Write_register !== 5'd5) begin
            mismatched++; $display("FAIL single_idle: got we=%b reg=%0d want 0/5", RegWrite, Write_register);
        end
    endtask

    task automatic test_alternate();
        logic [4:0] exp_reg;
        do_reset();
        alu_valid = 1; alu_reg = 1; alu_data = 64'hA1;
        mem_valid = 1; mem_reg = 2; mem_data = 64'hB2;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
                mismatched++; $display("FAIL alt_grant%0d: got %b%b want %b%b", i, alu_ready, mem_ready, i % 2 == 0, i % 2 == 1);
            end
            exp_reg = (i % 2 == 0) ? 5'd1 : 5'd2;
            @(negedge clk);
            compared++;
            if (RegWrite !== 1'b1 || Write_register !== exp_reg) begin
                mismatched++; $display("FAIL alt_out%0d: got we=%b reg=%0d want 1/%0d", i, RegWrite, Write_register, exp_reg);
            end
        end
        alu_valid = 0; mem_valid = 0;
    endtask

    task automatic test_mem_only();
        do_reset();
        mem_valid = 1; mem_reg = 6; mem_data = 64'h66;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
                mismatched++; $display("FAIL memonly%0d: got alu=%b mem=%b want 0/1", i, alu_ready, mem_ready);
            end
            @(negedge clk);
        end
        alu_valid = 1; alu_reg = 7; alu_data = 64'h77;
        #1;
        compared++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            mismatched++; $display("FAIL memonly_contend: got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        @(negedge clk);
        alu_valid = 0; mem_valid = 0;
    endtask

    task automatic test_forward();
        do_reset();
        alu_valid = 1; alu_reg = 7; alu_data = 64'hDEAD;
        @(negedge clk);
        alu_valid = 0; lkp_reg1 = 7; lkp_reg2 = 8;
        #1;
        compared++;
        if (fwd_hit1 !== 1'b1 || fwd_hit2 !== 1'b0 || fwd_data !== 64'hDEAD) begin
            mismatched++; $display("FAIL fwd_hit: got h1=%b h2=%b data=%h want 1/0/dead", fwd_hit1, fwd_hit2, fwd_data);
        end
        @(negedge clk);
        compared++;
        if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin
            mismatched++; $display("FAIL fwd_idle: got h1=%b h2=%b want 0/0", fwd_hit1, fwd_hit2);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        alu_valid = 1; mem_valid = 1; alu_reg = 10; mem_reg = 11;
        @(negedge clk);
        alu_reg = 9; alu_data = 64'h99; reset = 1;
        #1;
        compared++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            mismatched++; $display("FAIL mid_ready: got %b%b want 00", alu_ready, mem_ready);
        end
        @(negedge clk);
        compared++;
        if (RegWrite !== 1'b0 || Write_register !== 5'd0) begin
            mismatched++; $display("FAIL mid_out: got we=%b reg=%0d want 0/0", RegWrite, Write_register);
        end
        reset = 0;
        #1;
        compared++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            mismatched++; $display("FAIL mid_ptr: got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        @(negedge clk);
        alu_valid = 0; mem_valid = 0;
    endtask

    task automatic test_xzr();
        do_reset();
        alu_valid = 1; alu_reg = 31; alu_data = 64'h3131;
        #1;
        compared++;
        if (alu_ready !== 1'b1) begin
            mismatched++; $display("FAIL xzr_ready: got %b want 1", alu_ready);
        end
        @(negedge clk);
        alu_valid = 0; lkp_reg1 = 31;
        #1;
        compared++;
        if (RegWrite !== !XZR || fwd_hit1 !== !XZR || (!XZR && Write_register !== 5'd31)) begin
            mismatched++; $display("FAIL xzr_out: got we=%b hit=%b reg=%0d want we=%b hit=%b", RegWrite, fwd_hit1, Write_register, !XZR, !XZR);
        end
    endtask

    task automatic test_random();
        logic       turn_mem;
        logic       e_we;
        logic [4:0] e_reg;
        logic [N:0] e_data;
        logic       ga, gm, eh1, eh2;
        logic       alu_pend, mem_pend;
        do_reset();
        turn_mem = 0; e_we = 0; e_reg = 0; e_data = '0; alu_pend = 0; mem_pend = 0;
        for (int c = 0; c < 400; c++) begin
            if (!alu_pend) begin
                alu_valid = $urandom_range(0, 1);
                alu_reg = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
                alu_data = {$urandom, $urandom};
            end
            if (!mem_pend) begin
                mem_valid = $urandom_range(0, 1);
                mem_reg = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
                mem_data = {$urandom, $urandom};
            end
            lkp_reg1 = $urandom_range(0, 1) ? e_reg : 5'($urandom);
            lkp_reg2 = $urandom_range(0, 2) == 0 ? e_reg : 5'($urandom);
            reset = ($urandom_range(0, 39) == 0);
            #1;
            eh1 = e_we && lkp_reg1 == e_reg && !(XZR && lkp_reg1 == 5'd31);
            eh2 = e_we && lkp_reg2 == e_reg && !(XZR && lkp_reg2 == 5'd31);
            compared++;
            if (RegWrite !== e_we || Write_register !== e_reg || Write_data !== e_data) begin
                mismatched++; $display("FAIL rnd_out c=%0d: got %b/%0d/%h want %b/%0d/%h", c, RegWrite, Write_register, Write_data, e_we, e_reg, e_data);
            end
            compared++;
            if (fwd_hit1 !== eh1 || fwd_hit2 !== eh2 || fwd_data !== e_data) begin
                mismatched++; $display("FAIL rnd_fwd c=%0d: got %b%b want %b%b", c, fwd_hit1, fwd_hit2, eh1, eh2);
            end
            // Contention goes to whoever's turn it is; otherwise the sole requester wins.
            ga = !reset && alu_valid && (!mem_valid || !turn_mem);
            gm = !reset && mem_valid && (!alu_valid || turn_mem);
            compared++;
            if (alu_ready !== ga || mem_ready !== gm) begin
                mismatched++; $display("FAIL rnd_grant c=%0d: got %b%b want %b%b", c, alu_ready, mem_ready, ga, gm);
            end
            if (reset) begin
                e_we = 0; e_reg = 0; e_data = '0; turn_mem = 0;
            end else begin
                e_we = 0;
                if (ga || gm) begin
                    e_reg = gm ? mem_reg : alu_reg;
                    e_data = gm ? mem_data : alu_data;
                    e_we = !(XZR && e_reg == 5'd31);
                end
                if (alu_valid && mem_valid) turn_mem = !turn_mem;
            end
            alu_pend = alu_valid && !ga;
            mem_pend = mem_valid && !gm;
            @(negedge clk);
        end
        reset = 0; alu_valid = 0; mem_valid = 0;
    endtask

    initial begin
        reset = 1; alu_valid = 0; mem_valid = 0; alu_reg = 0; mem_reg = 0;
        alu_data = '0; mem_data = '0; lkp_reg1 = 0; lkp_reg2 = 0;
        test_reset();
        test_single();
        test_alternate();
        test_mem_only();
        test_forward();
        test_reset_midstream();
        test_xzr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
